// File: rtl/blob_pkg.sv
// Shared constants and state encoding for the blob feeder and its pixel pipeline.
package blob_pkg;
    localparam int IMG_COL = 640;
    localparam int IMG_ROW = 480;
    localparam int NPIX    = IMG_COL * IMG_ROW;
    localparam int ADDR_W  = 19;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } feeder_state_e;
endpackage

// File: rtl/blob_pix_pipe.sv
// Tracks which read-data cycles carry a real pixel and binarizes them against the latched threshold.
module blob_pix_pipe
    import blob_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rd_en,
    input  logic [7:0] i_rd_data,
    input  logic [7:0] i_thr,
    output logic       o_data_vld,
    output logic       o_seq
);
    logic [RD_LAT-1:0] vld_sr;

    // Bit RD_LAT-1 is high exactly in the cycle the memory presents a requested pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_sr <= '0;
            o_seq  <= 1'b0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(i_rd_en);
            o_seq  <= vld_sr[RD_LAT-1] && (i_rd_data >= i_thr);
        end
    end

    assign o_data_vld = vld_sr[RD_LAT-1];
endmodule

// File: rtl/blob_feeder.sv
// Scans one frame out of memory, streams binarized pixels to a blob counter and captures its result.
// Handshake: a frame is requested by i_start in IDLE only; o_valid frames the pixel stream and stays high until i_done or timeout.
module blob_feeder #(
    parameter int IMG_COL  = blob_pkg::IMG_COL,
    parameter int IMG_ROW  = blob_pkg::IMG_ROW,
    parameter int RD_LAT   = 2,
    parameter int DONE_TMO = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_threshold,
    output logic [18:0] o_rd_addr,
    output logic        o_rd_en,
    input  logic [7:0]  i_rd_data,
    output logic        o_valid,
    output logic        o_seq,
    input  logic        i_done,
    input  logic [7:0]  i_count,
    output logic [7:0]  o_count,
    output logic        o_count_valid,
    output logic        o_busy,
    output logic        o_timeout,
    output logic [2:0]  o_state
);
    localparam int NPIX_L = IMG_COL * IMG_ROW;
    localparam int TMO_W  = $clog2(DONE_TMO + 1);
    localparam int DRN_W  = $clog2(RD_LAT + 1);
    localparam logic [blob_pkg::ADDR_W-1:0] LAST_ADDR = blob_pkg::ADDR_W'(NPIX_L - 1);

    blob_pkg::feeder_state_e state_q, state_d;
    logic [blob_pkg::ADDR_W-1:0] addr_q;
    logic [7:0]       thr_q;
    logic [DRN_W-1:0] drn_q;
    logic [TMO_W-1:0] tmo_q;
    logic             rel_q;
    logic             valid_q;
    logic             data_vld;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(DONE_TMO - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= blob_pkg::ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            blob_pkg::ST_IDLE:      if (i_start) state_d = blob_pkg::ST_STREAM;
            blob_pkg::ST_STREAM:    if (addr_q == LAST_ADDR) state_d = blob_pkg::ST_DRAIN;
            blob_pkg::ST_DRAIN:     if (drn_q == DRN_W'(RD_LAT)) state_d = blob_pkg::ST_WAIT_DONE;
            blob_pkg::ST_WAIT_DONE: if (i_done || tmo_hit) state_d = blob_pkg::ST_RELEASE;
            blob_pkg::ST_RELEASE:   if (rel_q) state_d = blob_pkg::ST_IDLE;
            default:                state_d = blob_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en = (state_q == blob_pkg::ST_STREAM);
        o_busy  = (state_q != blob_pkg::ST_IDLE);
        o_valid = valid_q | data_vld;
        o_state = state_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q        <= '0;
            thr_q         <= '0;
            drn_q         <= '0;
            tmo_q         <= '0;
            rel_q         <= 1'b0;
            valid_q       <= 1'b0;
            o_count       <= '0;
            o_count_valid <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_count_valid <= 1'b0;
            case (state_q)
                blob_pkg::ST_IDLE: begin
                    if (i_start) begin
                        thr_q     <= i_threshold;
                        o_timeout <= 1'b0;
                        addr_q    <= '0;
                    end
                end
                blob_pkg::ST_STREAM: begin
                    if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
                end
                blob_pkg::ST_WAIT_DONE: begin
                    // A result arriving on the last allowed cycle wins over the timeout.
                    if (i_done) begin
                        o_count       <= i_count;
                        o_count_valid <= 1'b1;
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase

            drn_q <= (state_q == blob_pkg::ST_DRAIN) ? drn_q + 1'b1 : '0;
            if (state_q != blob_pkg::ST_WAIT_DONE)  tmo_q <= '0;
            else if (tmo_q != TMO_W'(DONE_TMO))     tmo_q <= tmo_q + 1'b1;
            rel_q <= (state_q == blob_pkg::ST_RELEASE) && !rel_q;

            if (data_vld) valid_q <= 1'b1;
            else if (state_q == blob_pkg::ST_WAIT_DONE && state_d == blob_pkg::ST_RELEASE) valid_q <= 1'b0;
        end
    end

    assign o_rd_addr = addr_q;

    blob_pix_pipe #(.RD_LAT(RD_LAT)) u_pix_pipe (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_en    (o_rd_en),
        .i_rd_data  (i_rd_data),
        .i_thr      (thr_q),
        .o_data_vld (data_vld),
        .o_seq      (o_seq)
    );
endmodule

// File: tb/tb_blob_feeder.sv
// Directed bench for blob_feeder on a reduced 16x4 frame with a 2-cycle memory model.
module tb_blob_feeder;
    localparam int N   = 64;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_threshold = 8'h00;
    logic [18:0] o_rd_addr;
    logic        o_rd_en;
    logic [7:0]  i_rd_data = 8'h00;
    logic        o_valid, o_seq;
    logic        i_done = 1'b0;
    logic [7:0]  i_count = 8'h00;
    logic [7:0]  o_count;
    logic        o_count_valid, o_busy, o_timeout;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [N];
    logic [7:0] rd_pipe = 8'h00;

    int obs_first_valid, obs_valid_fall, obs_valid_hi, obs_ones, obs_seq_bad;
    int obs_rd_bad, obs_rd_cycles, obs_cv_cnt, obs_cv_t, obs_to_t, obs_idle_t;
    logic [7:0] obs_cv_val;

    blob_feeder #(.IMG_COL(16), .IMG_ROW(4), .RD_LAT(2), .DONE_TMO(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_threshold   (i_threshold),
        .o_rd_addr     (o_rd_addr),
        .o_rd_en       (o_rd_en),
        .i_rd_data     (i_rd_data),
        .o_valid       (o_valid),
        .o_seq         (o_seq),
        .i_done        (i_done),
        .i_count       (i_count),
        .o_count       (o_count),
        .o_count_valid (o_count_valid),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    // Frame memory with two cycles of read latency; data is presented every cycle regardless of o_rd_en.
    always @(posedge clk) begin
        rd_pipe   <= mem[o_rd_addr[5:0]];
        i_rd_data <= rd_pipe;
    end

    task automatic fill_flat(input logic [7:0] v);
        for (int k = 0; k < N; k++) mem[k] = v;
    endtask

    task automatic fill_checker();
        for (int k = 0; k < N; k++) mem[k] = (((k / 16) + (k % 16)) % 2 == 1) ? 8'h80 : 8'h7F;
    endtask

    // Runs one frame; t=0 is the first cycle after the accepted start edge.
    task automatic scan(input logic [7:0] thr, input logic [7:0] thr_mid, input int done_at,
                        input logic [7:0] cnt, input int t_end, input bit extra_start);
        logic [0:0] exp_q[$];
        logic [0:0] e;
        exp_q = {};
        for (int k = 0; k < N; k++) exp_q.push_back(mem[k] >= thr);
        obs_first_valid = -1; obs_valid_fall = -1; obs_valid_hi = 0; obs_ones = 0; obs_seq_bad = 0;
        obs_rd_bad = 0; obs_rd_cycles = 0; obs_cv_cnt = 0; obs_cv_t = -1; obs_to_t = -1; obs_idle_t = -1;
        obs_cv_val = 8'h00;
        @(negedge clk);
        i_threshold = thr;
        i_count     = cnt;
        i_start     = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            if (o_valid) begin
                obs_valid_hi++;
                if (obs_first_valid < 0) obs_first_valid = t;
            end else if (obs_first_valid >= 0 && obs_valid_fall < 0) begin
                obs_valid_fall = t;
            end
            e = 1'b0;
            if (t >= 3 && t < 3 + N) e = exp_q.pop_front();
            if (o_seq !== e) obs_seq_bad++;
            if (o_seq === 1'b1) obs_ones++;
            if (o_rd_en === 1'b1) begin
                obs_rd_cycles++;
                if (o_rd_addr !== 19'(t)) obs_rd_bad++;
            end else if (t < N) begin
                obs_rd_bad++;
            end
            if (o_count_valid === 1'b1) begin
                obs_cv_cnt++;
                obs_cv_t   = t;
                obs_cv_val = o_count;
            end
            if (o_timeout === 1'b1 && obs_to_t < 0) obs_to_t = t;
            if (o_busy === 1'b0 && obs_idle_t < 0) obs_idle_t = t;
            i_done  = (t == done_at);
            i_start = extra_start && (t == 10 || t == N + 5);
            if (t == N / 2) i_threshold = thr_mid;
        end
        i_done  = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({o_valid, o_seq, o_rd_en, o_rd_addr, o_count, o_count_valid, o_busy, o_timeout} !== 33'd0) begin
            errors++; $display("FAIL reset_outputs got %h expected 0", {o_valid, o_seq, o_rd_en, o_rd_addr, o_count, o_count_valid, o_busy, o_timeout});
        end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", o_state); end
        i_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", o_busy); end
    endtask

    task automatic test_all_ones();
        fill_flat(8'h80);
        scan(8'h80, 8'h80, N + 12, 8'd5, N + 20, 1'b0);
        checks++; if (obs_first_valid !== 2) begin errors++; $display("FAIL ones_valid_rise got %0d expected 2", obs_first_valid); end
        checks++; if (obs_valid_hi !== N + 11) begin errors++; $display("FAIL ones_valid_len got %0d expected %0d", obs_valid_hi, N + 11); end
        checks++; if (obs_ones !== N) begin errors++; $display("FAIL ones_count got %0d expected %0d", obs_ones, N); end
        checks++; if (obs_seq_bad !== 0) begin errors++; $display("FAIL ones_seq got %0d bad cycles expected 0", obs_seq_bad); end
        checks++; if (obs_rd_bad !== 0 || obs_rd_cycles !== N) begin errors++; $display("FAIL ones_reads got %0d bad %0d cycles expected 0 bad %0d cycles", obs_rd_bad, obs_rd_cycles, N); end
        checks++; if (obs_cv_cnt !== 1 || obs_cv_t !== N + 13) begin errors++; $display("FAIL ones_cv got %0d pulses at %0d expected 1 at %0d", obs_cv_cnt, obs_cv_t, N + 13); end
        checks++; if (o_count !== 8'd5 || obs_cv_val !== 8'd5) begin errors++; $display("FAIL ones_o_count got %0d expected 5", o_count); end
        checks++; if (obs_idle_t !== N + 15) begin errors++; $display("FAIL ones_idle got %0d expected %0d", obs_idle_t, N + 15); end
        checks++; if (obs_to_t !== -1) begin errors++; $display("FAIL ones_timeout got %0d expected -1", obs_to_t); end
    endtask

    task automatic test_all_zeros();
        scan(8'h81, 8'h81, N + 12, 8'd9, N + 20, 1'b0);
        checks++; if (obs_ones !== 0 || obs_seq_bad !== 0) begin errors++; $display("FAIL zeros_seq got %0d ones %0d bad expected 0 0", obs_ones, obs_seq_bad); end
        checks++; if (obs_first_valid !== 2 || obs_valid_hi !== N + 11) begin errors++; $display("FAIL zeros_valid got rise %0d len %0d expected 2 %0d", obs_first_valid, obs_valid_hi, N + 11); end
        checks++; if (obs_rd_cycles !== N) begin errors++; $display("FAIL zeros_reads got %0d expected %0d", obs_rd_cycles, N); end
        checks++; if (o_count !== 8'd9) begin errors++; $display("FAIL zeros_o_count got %0d expected 9", o_count); end
    endtask

    task automatic test_checker_thr_change();
        fill_checker();
        scan(8'h80, 8'hFF, N + 12, 8'd3, N + 20, 1'b0);
        checks++; if (obs_seq_bad !== 0) begin errors++; $display("FAIL checker_seq got %0d bad cycles expected 0", obs_seq_bad); end
        checks++; if (obs_ones !== N / 2) begin errors++; $display("FAIL checker_ones got %0d expected %0d", obs_ones, N / 2); end
        checks++; if (o_count !== 8'd3) begin errors++; $display("FAIL checker_o_count got %0d expected 3", o_count); end
    endtask

    task automatic test_timeout();
        scan(8'h80, 8'h80, -1, 8'd77, N + 4110, 1'b0);
        checks++; if (obs_to_t !== N + 3 + TMO) begin errors++; $display("FAIL tmo_time got %0d expected %0d", obs_to_t, N + 3 + TMO); end
        checks++; if (obs_valid_fall !== N + 3 + TMO) begin errors++; $display("FAIL tmo_valid_fall got %0d expected %0d", obs_valid_fall, N + 3 + TMO); end
        checks++; if (obs_idle_t - obs_valid_fall !== 2) begin errors++; $display("FAIL tmo_release_len got %0d expected 2", obs_idle_t - obs_valid_fall); end
        checks++; if (obs_cv_cnt !== 0 || o_count !== 8'd3) begin errors++; $display("FAIL tmo_count got %0d pulses count %0d expected 0 3", obs_cv_cnt, o_count); end
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b expected 1", o_timeout); end
    endtask

    task automatic test_start_ignored();
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL ign_pre_timeout got %b expected 1", o_timeout); end
        scan(8'h80, 8'h80, N + 12, 8'd7, N + 20, 1'b1);
        checks++; if (obs_rd_cycles !== N || obs_rd_bad !== 0) begin errors++; $display("FAIL ign_reads got %0d cycles %0d bad expected %0d 0", obs_rd_cycles, obs_rd_bad, N); end
        checks++; if (obs_to_t !== -1) begin errors++; $display("FAIL ign_timeout_clear got %0d expected -1", obs_to_t); end
        checks++; if (obs_cv_cnt !== 1 || obs_idle_t !== N + 15) begin errors++; $display("FAIL ign_frame_end got %0d pulses idle %0d expected 1 %0d", obs_cv_cnt, obs_idle_t, N + 15); end
        checks++; if (o_count !== 8'd7) begin errors++; $display("FAIL ign_o_count got %0d expected 7", o_count); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        @(negedge clk);
        i_threshold = 8'h80;
        i_start     = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_rd_en === 1'b1 && o_rd_addr === 19'd40) break;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL rst_reach_addr got timeout expected addr 40"); end
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_valid, o_seq, o_rd_en, o_rd_addr, o_count, o_count_valid, o_busy, o_timeout} !== 33'd0) begin
            errors++; $display("FAIL rst_mid_outputs got %h expected 0", {o_valid, o_seq, o_rd_en, o_rd_addr, o_count, o_count_valid, o_busy, o_timeout});
        end
        repeat (3) @(negedge clk);
        checks++; if ({o_valid, o_seq, o_rd_en, o_busy} !== 4'd0) begin errors++; $display("FAIL rst_hold_outputs got %b expected 0", {o_valid, o_seq, o_rd_en, o_busy}); end
        i_rst_n = 1'b1;
        scan(8'h80, 8'h80, N + 12, 8'd4, N + 20, 1'b0);
        checks++; if (obs_rd_bad !== 0 || obs_first_valid !== 2) begin errors++; $display("FAIL rst_restart got %0d bad rise %0d expected 0 2", obs_rd_bad, obs_first_valid); end
        checks++; if (obs_seq_bad !== 0 || obs_ones !== N / 2) begin errors++; $display("FAIL rst_restart_seq got %0d bad %0d ones expected 0 %0d", obs_seq_bad, obs_ones, N / 2); end
        checks++; if (o_count !== 8'd4) begin errors++; $display("FAIL rst_restart_count got %0d expected 4", o_count); end
    endtask

    initial begin
        fill_flat(8'h00);
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_checker_thr_change();
        test_timeout();
        test_start_ignored();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blob_feeder.md
BLOB_FEEDER -- requirements
Module: blob_feeder

Interface
REQ-001 SHALL have parameters: IMG_COL, default 640, pixels per row.
REQ-002 SHALL have parameters: IMG_ROW, default 480, rows per frame.
REQ-003 SHALL have parameters: RD_LAT, default 2, frame-memory read latency in cycles.
REQ-004 SHALL have parameters: DONE_TMO, default 4096, max cycles from last pixel to i_done.
REQ-005 i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low; clock i_clk.
REQ-006 i_start  in  1  request one frame scan; sampled only in IDLE.
REQ-007 i_threshold  in  8  binarization threshold.
REQ-008 o_rd_addr  out  19  frame-memory read address, linear row-major.
REQ-009 o_rd_en  out  1  read strobe.
REQ-010 i_rd_data  in  8  gray pixel, valid RD_LAT cycles after the o_rd_en cycle.
REQ-011 o_valid  out  1  frame-active to blob counter.
REQ-012 o_seq  out  1  binary pixel to blob counter.
REQ-013 i_done  in  1  blob counter result valid.
REQ-014 i_count  in  8  blob count.
REQ-015 o_count  out  8  last captured count.
REQ-016 o_count_valid  out  1  one-cycle pulse when o_count updates.
REQ-017 o_busy  out  1  high in any state other than IDLE.
REQ-018 o_timeout  out  1  sticky; cleared by the next accepted i_start.

Function
REQ-019 FSM states SHALL be IDLE, STREAM, DRAIN, WAIT_DONE and RELEASE.
REQ-020 IDLE with i_start=1 at edge E SHALL latch i_threshold into thr_q, clear o_timeout, and enter STREAM; first address issued in the cycle after E (call it C0).
REQ-021 STREAM SHALL assert o_rd_en every cycle with o_rd_addr=0,1,...,NPIX-1 (NPIX=IMG_COL*IMG_ROW=307200), then enter DRAIN; there are no bubbles.
REQ-022 o_seq SHALL be registered (i_rd_data >= thr_q); pixel k appears on o_seq in cycle C0+RD_LAT+1+k.
REQ-023 o_valid SHALL rise in cycle C0+RD_LAT, exactly one cycle before pixel 0, and stay high through WAIT_DONE.
REQ-024 o_seq SHALL be 0 whenever no pixel is scheduled.
REQ-025 DRAIN SHALL last RD_LAT+1 cycles until the last pixel is emitted, then enter WAIT_DONE with the timeout counter at 0.
REQ-026 WAIT_DONE with i_done=1 SHALL latch i_count into o_count, pulse o_count_valid for one cycle, and enter RELEASE.
REQ-027 WAIT_DONE without i_done for DONE_TMO cycles SHALL set o_timeout, leave o_count unchanged, and enter RELEASE.
REQ-028 RELEASE SHALL hold o_valid=0 for 2 cycles, then enter IDLE; i_done is ignored outside WAIT_DONE.
REQ-029 i_start SHALL be ignored while o_busy=1; a change to i_threshold mid-frame SHALL have no effect.
REQ-030 Address counter SHALL be 19 bits and SHALL stop at NPIX-1, with no wrap.
REQ-031 Timeout counter SHALL be clog2(DONE_TMO+1) bits and saturating.

Reset
REQ-032 Assertion of i_rst_n at any time, including mid-frame, SHALL force IDLE with all outputs 0: o_valid, o_seq, o_rd_en, o_rd_addr, o_count, o_count_valid, o_busy, o_timeout; in-flight read data SHALL be discarded.
REQ-033 The first i_start after reset release SHALL behave as in REQ-020.

Structure
REQ-034 Shared package blob_pkg SHALL hold IMG_COL, IMG_ROW, NPIX, the address width (19), and the feeder state enum.
REQ-035 A single sub-module, blob_pix_pipe, SHALL contain the RD_LAT-deep valid shift register and the registered threshold compare; the FSM and counters remain in blob_feeder.

Verification
REQ-036 Memory all 0x80, thr=0x80, i_done asserted 10 cycles after the last pixel with i_count=5 -> o_valid rises at C0+2; 307200 ones on o_seq; o_count=5; single o_count_valid pulse.
REQ-037 thr=0x81 on same memory -> o_seq all 0; pixel count and o_valid timing identical to REQ-036.
REQ-038 Checkerboard memory, thr changed mid-frame -> o_seq matches thr_q latched at start, bit-exact against model.
REQ-039 i_done never asserted -> o_timeout=1 exactly 4096 cycles into WAIT_DONE; o_valid low for 2 cycles; o_count unchanged.
REQ-040 i_rst_n asserted at pixel 1000, then released, then i_start -> all outputs 0 during reset; new frame restarts at address 0.
REQ-041 i_start pulses during STREAM and WAIT_DONE -> ignored; exactly one frame issued.
